// File: rtl/data_mem_responder.sv
// Memory-side responder: one RAM port shared round-robin by per-channel read/write
// valid/ready requesters, with a fixed grant-to-response latency and a backdoor load port.
module data_mem_responder #(
   parameter int unsigned ADDR_BITS    = 8,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned LATENCY      = 2
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_CHANNELS-1:0]               mem_read_valid,
   input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
   output logic [NUM_CHANNELS-1:0]               mem_read_ready,
   output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
   input  logic [NUM_CHANNELS-1:0]               mem_write_valid,
   input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
   input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
   output logic [NUM_CHANNELS-1:0]               mem_write_ready,
   input  logic                                  load_enable,
   input  logic [ADDR_BITS-1:0]                  load_address,
   input  logic [DATA_BITS-1:0]                  load_data,
   output logic                                  busy
);

   localparam int unsigned REQ_W = 2 * NUM_CHANNELS;
   localparam int unsigned PTR_W = (REQ_W > 1) ? $clog2(REQ_W) : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ACCESS  = 2'd1;
   localparam logic [1:0] RESPOND = 2'd2;

   logic [DATA_BITS-1:0] ram [2**ADDR_BITS];

   logic [1:0]                              state_q;
   logic [PTR_W-1:0]                        rr_q;
   logic [PTR_W-1:0]                        grant_q;
   logic [ADDR_BITS-1:0]                    addr_q;
   logic [DATA_BITS-1:0]                    data_q;
   logic [3:0]                              cnt_q;
   logic [NUM_CHANNELS-1:0]                 read_ready_q;
   logic [NUM_CHANNELS-1:0]                 write_ready_q;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  read_data_q;

   logic [REQ_W-1:0]     req;
   logic                 found;
   logic [PTR_W-1:0]     pick;
   logic [PTR_W-1:0]     idx;
   logic [PTR_W-1:0]     rr_next;
   logic [ADDR_BITS-1:0] pick_addr;
   logic [DATA_BITS-1:0] pick_data;
   logic                 commit_wr;

   // Requester k = 2*ch + (0 read / 1 write)
   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_req
      assign req[2*c]   = mem_read_valid[c];
      assign req[2*c+1] = mem_write_valid[c];
   end

   always_comb begin
      found     = 1'b0;
      pick      = '0;
      idx       = '0;
      pick_addr = '0;
      pick_data = '0;
      for (int i = 0; i < int'(REQ_W); i++) begin
         idx = PTR_W'((int'(rr_q) + i) % int'(REQ_W));
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
         if (pick == PTR_W'(2*c)) begin
            pick_addr = mem_read_address[c];
         end
         if (pick == PTR_W'(2*c+1)) begin
            pick_addr = mem_write_address[c];
            pick_data = mem_write_data[c];
         end
      end
      rr_next = (pick == PTR_W'(REQ_W-1)) ? '0 : pick + PTR_W'(1);
   end

   assign commit_wr = (state_q == ACCESS) && (cnt_q == 4'd0) && grant_q[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         rr_q          <= '0;
         grant_q       <= '0;
         addr_q        <= '0;
         data_q        <= '0;
         cnt_q         <= 4'd0;
         read_ready_q  <= '0;
         write_ready_q <= '0;
         read_data_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  grant_q <= pick;
                  addr_q  <= pick_addr;
                  data_q  <= pick_data;
                  cnt_q   <= 4'(LATENCY - 1);
                  rr_q    <= rr_next;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                     if (grant_q == PTR_W'(2*c)) begin
                        read_data_q[c]  <= ram[addr_q];
                        read_ready_q[c] <= 1'b1;
                     end else if (grant_q == PTR_W'(2*c+1)) begin
                        write_ready_q[c] <= 1'b1;
                     end
                  end
                  state_q <= RESPOND;
               end
            end
            RESPOND: begin
               // A valid already dropped during ACCESS gives a single-cycle ready
               if (!req[grant_q]) begin
                  read_ready_q  <= '0;
                  write_ready_q <= '0;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Channel write is ordered after the load so it wins on an address collision
   always_ff @(posedge clk) begin
      if (load_enable) begin
         ram[load_address] <= load_data;
      end
      if (commit_wr) begin
         ram[addr_q] <= data_q;
      end
   end

   assign mem_read_ready  = read_ready_q;
   assign mem_write_ready = write_ready_q;
   assign mem_read_data   = read_data_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected responses are queued when requests
// are driven and compared in order as ready pulses appear.
module tb_data_mem_responder;

   localparam int NCH = 4;

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic [NCH-1:0]           mem_read_valid = '0;
   logic [NCH-1:0][7:0]      mem_read_address = '0;
   logic [NCH-1:0]           mem_read_ready;
   logic [NCH-1:0][7:0]      mem_read_data;
   logic [NCH-1:0]           mem_write_valid = '0;
   logic [NCH-1:0][7:0]      mem_write_address = '0;
   logic [NCH-1:0][7:0]      mem_write_data = '0;
   logic [NCH-1:0]           mem_write_ready;
   logic                     load_enable = 1'b0;
   logic [7:0]               load_address = '0;
   logic [7:0]               load_data = '0;
   logic                     busy;

   typedef struct {
      bit         wr;
      int         ch;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] model [256];
   int         n_checks = 0;
   int         n_fail = 0;

   data_mem_responder #(
      .ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(NCH), .LATENCY(2)
   ) dut (
      .clk(clk), .reset(reset),
      .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
      .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
      .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
      .load_enable(load_enable), .load_address(load_address), .load_data(load_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] d);
      load_enable  = 1'b1;
      load_address = a;
      load_data    = d;
      tick();
      load_enable  = 1'b0;
      model[a]     = d;
   endtask

   task automatic push(input bit wr, input int ch, input logic [7:0] d);
      exp_t e;
      e.wr   = wr;
      e.ch   = ch;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic set_req(input bit wr, input int ch, input logic [7:0] a, input logic [7:0] d,
                          input bit v);
      if (wr) begin
         mem_write_address[ch] = a;
         mem_write_data[ch]    = d;
         mem_write_valid[ch]   = v;
      end else begin
         mem_read_address[ch]  = a;
         mem_read_valid[ch]    = v;
      end
   endtask

   function automatic logic rdy(input bit wr, input int ch);
      return wr ? mem_write_ready[ch] : mem_read_ready[ch];
   endfunction

   // Full handshake on one channel; expected response queued at drive time
   task automatic do_req(input bit wr, input int ch, input logic [7:0] a, input logic [7:0] d);
      int n;
      push(wr, ch, wr ? d : model[a]);
      if (wr) model[a] = d;
      set_req(wr, ch, a, d, 1'b1);
      n = 0;
      while (!rdy(wr, ch) && n < 50) begin
         tick();
         n++;
      end
      check("req_timeout", 32'(n < 50), 32'd1);
      set_req(wr, ch, a, d, 1'b0);
      tick();
      check("ready_drop", 32'(rdy(wr, ch)), 32'd0);
   endtask

   // Serve all raised reads; optionally re-raise one channel right after its first service
   task automatic serve_reads(input int rereq_ch);
      int n;
      bit rr_done, rr_pend;
      n = 0;
      rr_done = 1'b0;
      rr_pend = 1'b0;
      while ((mem_read_valid != '0 || busy || rr_pend) && n < 200) begin
         tick();
         n++;
         if (rr_pend) begin
            mem_read_valid[rereq_ch] = 1'b1;
            rr_pend = 1'b0;
         end
         if ((mem_read_ready | mem_write_ready) != '0) check("busy_with_ready", 32'(busy), 32'd1);
         for (int c = 0; c < NCH; c++) begin
            if (mem_read_ready[c] && mem_read_valid[c]) begin
               mem_read_valid[c] = 1'b0;
               if (c == rereq_ch && !rr_done) begin
                  rr_pend = 1'b1;
                  rr_done = 1'b1;
               end
            end
         end
      end
      check("serve_timeout", 32'(n < 200), 32'd1);
   endtask

   task automatic got(input bit wr, input int ch);
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("resp_type", 32'(wr), 32'(e.wr));
         check("resp_ch", 32'(ch), 32'(e.ch));
         if (!wr) check("resp_data", 32'(mem_read_data[ch]), 32'(e.data));
      end
   endtask

   // Monitor: one-hot ready and in-order scoreboard comparison on each new ready pulse
   initial begin
      logic [NCH-1:0] pr, pw;
      pr = '0;
      pw = '0;
      forever begin
         @(negedge clk);
         check("ready_onehot", 32'($countones({mem_write_ready, mem_read_ready}) <= 1), 32'd1);
         for (int c = 0; c < NCH; c++) begin
            if (mem_read_ready[c] && !pr[c]) got(1'b0, c);
            if (mem_write_ready[c] && !pw[c]) got(1'b1, c);
         end
         pr = mem_read_ready;
         pw = mem_write_ready;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      #2;
      check("rst_ready", 32'({mem_write_ready, mem_read_ready}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rdata", 32'(mem_read_data), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick();

      // Exact latency on a ch0 read
      load(8'h10, 8'h5A);
      push(1'b0, 0, 8'h5A);
      set_req(1'b0, 0, 8'h10, 8'h00, 1'b1);
      tick();
      check("t1_busy_grant", 32'(busy), 32'd1);
      check("t1_ready_e1", 32'(mem_read_ready), 32'd0);
      tick();
      check("t1_ready_e2", 32'(mem_read_ready), 32'd0);
      tick();
      check("t1_ready_e3", 32'(mem_read_ready), 32'h1);
      check("t1_data", 32'(mem_read_data[0]), 32'h5A);
      set_req(1'b0, 0, 8'h10, 8'h00, 1'b0);
      tick();
      check("t1_ready_drop", 32'(mem_read_ready), 32'd0);
      check("t1_busy_idle", 32'(busy), 32'd0);

      // Write then read back on another channel
      do_req(1'b1, 1, 8'h20, 8'h33);
      do_req(1'b0, 2, 8'h20, 8'h00);
      check("t2_rdata2", 32'(mem_read_data[2]), 32'h33);

      // Top address; ch3 write (requester 7) wraps the pointer to 0
      load(8'hFF, 8'hC3);
      do_req(1'b0, 2, 8'hFF, 8'h00);
      do_req(1'b1, 3, 8'hFF, 8'h9E);

      // Simultaneous reads on all channels: served 0,1,2,3
      push(1'b0, 0, model[8'hFF]);
      push(1'b0, 1, model[8'h10]);
      push(1'b0, 2, model[8'h20]);
      push(1'b0, 3, model[8'hFF]);
      set_req(1'b0, 0, 8'hFF, 8'h00, 1'b1);
      set_req(1'b0, 1, 8'h10, 8'h00, 1'b1);
      set_req(1'b0, 2, 8'h20, 8'h00, 1'b1);
      set_req(1'b0, 3, 8'hFF, 8'h00, 1'b1);
      serve_reads(-1);
      check("t3_rdata0", 32'(mem_read_data[0]), 32'h9E);

      // Fairness: ch3 pending beats ch0's immediate re-request
      push(1'b0, 0, model[8'h10]);
      push(1'b0, 3, model[8'h20]);
      push(1'b0, 0, model[8'h10]);
      set_req(1'b0, 0, 8'h10, 8'h00, 1'b1);
      set_req(1'b0, 3, 8'h20, 8'h00, 1'b1);
      serve_reads(0);

      // Valid dropped right after grant: access completes, ready pulses once
      push(1'b1, 2, 8'h66);
      model[8'h40] = 8'h66;
      set_req(1'b1, 2, 8'h40, 8'h66, 1'b1);
      tick();
      set_req(1'b1, 2, 8'h40, 8'h66, 1'b0);
      cnt = 0;
      repeat (6) begin
         tick();
         if (mem_write_ready[2]) cnt++;
      end
      check("viol_pulse", 32'(cnt), 32'd1);
      check("viol_idle", 32'(busy), 32'd0);
      do_req(1'b0, 1, 8'h40, 8'h00);

      // Reset during ACCESS: no commit, ready stays low, RAM keeps old value
      load(8'h30, 8'h11);
      set_req(1'b1, 1, 8'h30, 8'h77, 1'b1);
      tick();
      check("t5_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("t5_ready", 32'({mem_write_ready, mem_read_ready}), 32'd0);
      check("t5_busy_rst", 32'(busy), 32'd0);
      check("t5_rdata_rst", 32'(mem_read_data), 32'd0);
      set_req(1'b1, 1, 8'h30, 8'h77, 1'b0);
      tick();
      tick();
      check("t5_ready_hold", 32'({mem_write_ready, mem_read_ready}), 32'd0);
      reset = 1'b1;
      tick();
      do_req(1'b0, 0, 8'h30, 8'h00);
      check("t5_ram_kept", 32'(mem_read_data[0]), 32'h11);

      repeat (3) tick();
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
